mdu_seq: RTL and testbench

- Multi-cycle sequencer for the multiply/divide resource in the EX stage. It accepts a start pulse and an operation code, then computes the result from operands latched at start.
- It holds Busy for a fixed latency that depends on the operation class, then commits the result into the HI/LO architectural registers.
- It also produces the decode-stage stall request for any instruction that touches HI/LO while an operation is pending.

---
 rtl/mdu_seq.sv | 105 ++++++++++
 tb/tb_mdu_seq.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide sequencer owning the HI/LO registers.
// Builds with or without MDU_CANCEL_EN; defining it adds flush_i to abandon an
// in-flight operation or suppress a launch.
module mdu_seq #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        d_md_use_i,
`ifdef MDU_CANCEL_EN
  input  logic        flush_i,
`endif
  output logic        busy_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stall_o
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q, dz_q;
  logic [31:0]        hi_q, lo_q, p_hi_q, p_lo_q;
  logic               is_mul, is_div, is_md, flush;
  logic [63:0]        prod;
  logic signed [31:0] sq, sr;
  logic [31:0]        uq, ur, p_hi_d, p_lo_d;
  logic [CW-1:0]      cnt_d;

`ifdef MDU_CANCEL_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Result datapath evaluated on the live operands; captured only at launch.
  always_comb begin
    is_mul = (op_i == 3'd1) || (op_i == 3'd2);
    is_div = (op_i == 3'd3) || (op_i == 3'd4);
    is_md  = is_mul || is_div;
    prod   = (op_i == 3'd1) ? {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i}
                            : {32'd0, a_i} * {32'd0, b_i};
    sq     = $signed(a_i) / $signed(b_i);
    sr     = $signed(a_i) % $signed(b_i);
    uq     = a_i / b_i;
    ur     = a_i % b_i;
    p_hi_d = is_mul ? prod[63:32] : (op_i == 3'd3) ? sr : ur;
    p_lo_d = is_mul ? prod[31:0]  : (op_i == 3'd3) ? sq : uq;
    cnt_d  = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
  end

  // Sequencer: launch, count down, commit HI/LO (skipped on divide by zero).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      p_hi_q  <= '0;
      p_lo_q  <= '0;
    end else if (state_q == IDLE) begin
      if (start_i && is_md && !flush) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
        cnt_q   <= cnt_d;
        p_hi_q  <= p_hi_d;
        p_lo_q  <= p_lo_d;
        dz_q    <= is_div && (b_i == 32'd0);
      end else if (start_i && op_i == 3'd5) begin
        hi_q <= a_i;
      end else if (start_i && op_i == 3'd6) begin
        lo_q <= a_i;
      end
    end else if (flush) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (cnt_q == CW'(1)) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      if (!dz_q) begin
        hi_q <= p_hi_q;
        lo_q <= p_lo_q;
      end
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign busy_o  = busy_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign stall_o = d_md_use_i & (busy_q | (start_i & is_md));
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed scoreboard bench for mdu_seq latency, results and stall.
module tb_mdu_seq;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  op_i = 3'd0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        d_md_use_i = 1'b0;
`ifdef MDU_CANCEL_EN
  logic        flush_i = 1'b0;
`endif
  logic        busy_o, stall_o;
  logic [31:0] hi_o, lo_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  mdu_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .d_md_use_i(d_md_use_i),
`ifdef MDU_CANCEL_EN
    .flush_i(flush_i),
`endif
    .busy_o(busy_o), .hi_o(hi_o), .lo_o(lo_o), .stall_o(stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Launch op at the next edge, count busy cycles, then pop and compare HI/LO.
  // inj_op != 0 drives a second start of that op while the first is running.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic use_d,
                        input logic [2:0] inj_op);
    int cnt;
    logic [63:0] e;
    @(negedge clk_i);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b; d_md_use_i = use_d;
    #1 chk({tag, "_stall_launch"}, {63'd0, stall_o}, {63'd0, use_d});
    @(negedge clk_i);
    start_i = 1'b0; op_i = 3'd0; a_i = $urandom; b_i = $urandom;
    cnt = 0;
    while (busy_o && cnt < 200) begin
      chk({tag, "_stall_busy"}, {63'd0, stall_o}, {63'd0, use_d});
      cnt++;
      if (cnt == 2 && inj_op != 3'd0) begin
        start_i = 1'b1; op_i = inj_op; a_i = 32'd5; b_i = 32'd5;
      end else begin
        start_i = 1'b0; op_i = 3'd0;
      end
      @(negedge clk_i);
    end
    start_i = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(cnt), 64'(n));
    chk({tag, "_stall_after"}, {63'd0, stall_o}, 64'd0);
    e = exp_q.pop_front();
    chk({tag, "_hilo"}, {hi_o, lo_o}, e);
    d_md_use_i = 1'b0;
  endtask

  initial begin
    d_md_use_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_stall", {63'd0, stall_o}, 64'd0);
    d_md_use_i = 1'b0;

    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFA});
    run_op("mult_neg", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b1, 3'd0);
    exp_q.push_back({32'h00000001, 32'hFFFFFFFE});
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 5, 1'b0, 3'd0);
    exp_q.push_back({32'h3FFFFFFF, 32'h00000001});
    run_op("mult_max", 3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5, 1'b0, 3'd0);
    exp_q.push_back({32'h00000000, 32'h00000001});
    run_op("mult_m1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b1, 3'd0);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b1, 3'd0);
    exp_q.push_back({32'hFFFFFFFF, 32'hFFFFFFFD});
    run_op("divu_zero", 3'd4, 32'd7, 32'd0, 10, 1'b0, 3'd0);
    exp_q.push_back({32'h00000001, 32'hFFFFFFFD});
    run_op("div_negb", 3'd3, 32'd7, 32'hFFFFFFFE, 10, 1'b0, 3'd0);
    exp_q.push_back({32'h00000002, 32'h0000000E});
    run_op("divu", 3'd4, 32'd100, 32'd7, 10, 1'b1, 3'd0);
    exp_q.push_back({32'h00000002, 32'h0000000E});
    run_op("div_zero", 3'd3, 32'hFFFFFFF9, 32'd0, 10, 1'b0, 3'd0);

    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'd5; a_i = 32'h12345678; d_md_use_i = 1'b1;
    #1 chk("mthi_stall", {63'd0, stall_o}, 64'd0);
    @(negedge clk_i);
    start_i = 1'b0; d_md_use_i = 1'b0;
    chk("mthi_busy", {63'd0, busy_o}, 64'd0);
    chk("mthi_hilo", {hi_o, lo_o}, {32'h12345678, 32'h0000000E});
    start_i = 1'b1; op_i = 3'd6; a_i = 32'hCAFEBABE;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("mtlo_busy", {63'd0, busy_o}, 64'd0);
    chk("mtlo_hilo", {hi_o, lo_o}, {32'h12345678, 32'hCAFEBABE});
    start_i = 1'b1; op_i = 3'd0; a_i = 32'h11111111; b_i = 32'h2;
    @(negedge clk_i);
    start_i = 1'b0;
    chk("nop_busy", {63'd0, busy_o}, 64'd0);
    chk("nop_hilo", {hi_o, lo_o}, {32'h12345678, 32'hCAFEBABE});

    exp_q.push_back({32'h00000000, 32'h0000000C});
    run_op("mult_inj", 3'd1, 32'd3, 32'd4, 5, 1'b1, 3'd1);
    exp_q.push_back({32'h00000000, 32'h00000015});
    run_op("mult_injmt", 3'd2, 32'd3, 32'd7, 5, 1'b0, 3'd5);

    @(negedge clk_i);
    start_i = 1'b1; op_i = 3'd3; a_i = 32'd100; b_i = 32'd3;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    chk("abort_busy_pre", {63'd0, busy_o}, 64'd1);
    rst_ni = 1'b0;
    #1 chk("abort_busy", {63'd0, busy_o}, 64'd0);
    chk("abort_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (12) @(negedge clk_i);
    chk("abort_no_commit", {hi_o, lo_o}, 64'd0);
    chk("abort_idle", {63'd0, busy_o}, 64'd0);

`ifdef MDU_CANCEL_EN
    exp_q.push_back({32'h00000000, 32'h00000006});
    run_op("mult_pre_flush", 3'd1, 32'd2, 32'd3, 5, 1'b0, 3'd0);
    start_i = 1'b1; op_i = 3'd1; a_i = 32'd9; b_i = 32'd9;
    @(negedge clk_i);
    start_i = 1'b0;
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    chk("flush_busy", {63'd0, busy_o}, 64'd0);
    chk("flush_hilo", {hi_o, lo_o}, {32'h0, 32'h6});
    start_i = 1'b1; op_i = 3'd4; a_i = 32'd9; b_i = 32'd2; flush_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_launch_busy", {63'd0, busy_o}, 64'd0);
    repeat (12) @(negedge clk_i);
    chk("flush_launch_hilo", {hi_o, lo_o}, {32'h0, 32'h6});
`endif

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
